// File: rtl/acl_spi_sampler_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package : acl_pkg
// Brief   : ADXL362 command/register constants, byte tables and sampler states.
// Rev     : 1.0
// ============================================================================
package acl_pkg;

  localparam logic [7:0] c_cmd_write         = 8'h0A;
  localparam logic [7:0] c_cmd_read          = 8'h0B;
  localparam logic [7:0] c_reg_power_ctl     = 8'h2D;
  localparam logic [7:0] c_reg_xdata         = 8'h08;
  localparam logic [7:0] c_power_ctl_measure = 8'h02;

  localparam int c_cfg_bytes  = 3;
  localparam int c_read_bytes = 5;

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_CFG      = 3'd1,
    ST_IDLE     = 3'd2,
    ST_READ     = 3'd3,
    ST_LATCH    = 3'd4
  } acl_state_t;

  function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return c_cmd_write;
      3'd1:    return c_reg_power_ctl;
      default: return c_power_ctl_measure;
    endcase
  endfunction

  // Bytes 2..4 are dummies that clock out X, Y, Z.
  function automatic logic [7:0] read_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return c_cmd_read;
      3'd1:    return c_reg_xdata;
      default: return 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/acl_spi_sampler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Interface : acl_spi_sampler_if
// Brief     : SPI bus between the sampler (master) and the ADXL362 (slave).
// Rev       : 1.0
// ============================================================================
interface acl_spi_sampler_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic miso;

  modport master (output sclk, output mosi, output cs_n, input miso);
  modport slave  (input sclk, input mosi, input cs_n, output miso);
endinterface
`default_nettype wire

// File: rtl/acl_spi_sampler_byte_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : spi_byte_engine
// Brief  : One mode-0 SPI byte, MSB first; restartable on done for gapless bursts.
// Rev    : 1.0
// ============================================================================
module spi_byte_engine #(
  parameter int CLK_DIV = 50
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       start,
  input  wire logic [7:0] tx_byte,
  input  wire logic       miso,
  output logic            sclk,
  output logic            mosi,
  output logic [7:0]      rx_byte,
  output logic            done
);

  localparam int c_div_w = $clog2(CLK_DIV + 1);

  logic               r_busy;
  logic [c_div_w-1:0] r_div;
  logic [3:0]         r_half;
  logic [6:0]         r_sh;
  logic [7:0]         r_rx;
  logic               r_miso_s1;
  logic               r_miso_s2;
  logic               w_edge;

  assign w_edge  = (r_div == c_div_w'(CLK_DIV - 1));
  assign done    = r_busy && w_edge && (r_half == 4'd15);
  assign rx_byte = r_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_div     <= '0;
      r_half    <= 4'd0;
      r_sh      <= 7'd0;
      r_rx      <= 8'd0;
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
      if (r_busy) begin
        if (w_edge) begin
          r_div  <= '0;
          r_half <= r_half + 4'd1;
          if (!r_half[0]) begin
            sclk <= 1'b1;
            r_rx <= {r_rx[6:0], r_miso_s2};
          end else begin
            sclk <= 1'b0;
            mosi <= r_sh[6];
            r_sh <= {r_sh[5:0], 1'b0};
            if (r_half == 4'd15) r_busy <= 1'b0;
          end
        end else begin
          r_div <= r_div + c_div_w'(1);
        end
      end
      // A start coinciding with done overrides the idle transition above.
      if (start) begin
        r_busy <= 1'b1;
        r_sh   <= tx_byte[6:0];
        mosi   <= tx_byte[7];
        r_div  <= '0;
        r_half <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/acl_spi_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : acl_spi_sampler
// Brief  : Configures the ADXL362 once, then samples X/Y/Z into a packed 15-bit word.
// Rev    : 1.0
// ============================================================================
module acl_spi_sampler #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 10_000_000,
  parameter int POWERUP_WAIT  = 600_000,
  parameter int CS_GAP        = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  acl_spi_sampler_if.master  spi,
  output logic [14:0]        acl_data,
  output logic               acl_valid
);
  import acl_pkg::*;

  // cs_n trails the last fall by one half-period, then stays high for the gap.
  localparam int c_tail       = (CS_GAP + 1) * CLK_DIV;
  localparam int c_cs_rise_at = CS_GAP * CLK_DIV + 1;

  acl_state_t  r_state;
  acl_state_t  w_state_n;
  logic [31:0] r_pwr_cnt;
  logic [31:0] r_timer;
  logic [31:0] r_post;
  logic [2:0]  r_idx;
  logic        r_cs_n;
  logic [4:0]  r_x;
  logic [4:0]  r_y;
  logic [4:0]  r_z;
  logic        w_start;
  logic [7:0]  w_tx;
  logic        w_begin;
  logic        w_last;
  logic        w_done;
  logic [7:0]  w_rx;
  logic        w_unused_rx_lsb;

  assign spi.cs_n        = r_cs_n;
  assign w_unused_rx_lsb = ^w_rx[2:0];

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .tx_byte (w_tx),
    .miso    (spi.miso),
    .sclk    (spi.sclk),
    .mosi    (spi.mosi),
    .rx_byte (w_rx),
    .done    (w_done)
  );

  always_comb begin
    w_state_n = r_state;
    w_start   = 1'b0;
    w_tx      = 8'h00;
    w_begin   = 1'b0;
    w_last    = 1'b0;
    unique case (r_state)
      ST_WAIT_PWR: begin
        if (r_pwr_cnt >= 32'(POWERUP_WAIT - 1)) begin
          w_state_n = ST_CFG;
          w_begin   = 1'b1;
          w_start   = 1'b1;
          w_tx      = c_cmd_write;
        end
      end
      ST_CFG: begin
        if (w_done) begin
          if (r_idx == 3'(c_cfg_bytes - 1)) begin
            w_last    = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_start = 1'b1;
            w_tx    = cfg_byte(r_idx + 3'd1);
          end
        end
      end
      ST_IDLE: begin
        // A timer that expired during a transaction holds at zero until here.
        if (r_post == 32'd0 && r_timer == 32'd0) begin
          w_state_n = ST_READ;
          w_begin   = 1'b1;
          w_start   = 1'b1;
          w_tx      = c_cmd_read;
        end
      end
      ST_READ: begin
        if (w_done) begin
          if (r_idx == 3'(c_read_bytes - 1)) begin
            w_last    = 1'b1;
            w_state_n = ST_LATCH;
          end else begin
            w_start = 1'b1;
            w_tx    = read_byte(r_idx + 3'd1);
          end
        end
      end
      ST_LATCH: w_state_n = ST_IDLE;
      default:  w_state_n = ST_WAIT_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_WAIT_PWR;
      r_pwr_cnt <= 32'd0;
      r_timer   <= 32'd0;
      r_post    <= 32'd0;
      r_idx     <= 3'd0;
      r_cs_n    <= 1'b1;
      r_x       <= 5'd0;
      r_y       <= 5'd0;
      r_z       <= 5'd0;
      acl_data  <= 15'd0;
      acl_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == ST_WAIT_PWR) r_pwr_cnt <= r_pwr_cnt + 32'd1;

      if (w_begin) begin
        r_cs_n <= 1'b0;
        r_idx  <= 3'd0;
      end else begin
        if (w_start) r_idx <= r_idx + 3'd1;
        if (r_post == 32'(c_cs_rise_at)) r_cs_n <= 1'b1;
      end

      if (w_last)              r_post <= 32'(c_tail);
      else if (r_post != 32'd0) r_post <= r_post - 32'd1;

      if (r_state == ST_CFG)     r_timer <= 32'd0;
      else if (w_begin)          r_timer <= 32'(SAMPLE_PERIOD - 1);
      else if (r_timer != 32'd0) r_timer <= r_timer - 32'd1;

      if (w_done && r_state == ST_READ) begin
        case (r_idx)
          3'd2:    r_x <= w_rx[7:3];
          3'd3:    r_y <= w_rx[7:3];
          3'd4:    r_z <= w_rx[7:3];
          default: ;
        endcase
      end

      acl_valid <= (r_state == ST_LATCH);
      if (r_state == ST_LATCH) acl_data <= {r_x, r_y, r_z};
    end
  end

endmodule
`default_nettype wire

// File: doc/acl_spi_sampler.md
# acl_spi_sampler

- Upstream stage of the snake game: it owns the SPI link to the on-board ADXL362 accelerometer.
- After reset it configures the part once, then reads X/Y/Z at a fixed rate.
- Each reading is packed into the 15-bit `acl_data` word that the game logic decodes for tilt direction.
- The packed word holds the signed top 5 bits of each axis and is updated atomically, with a one-cycle `acl_valid` strobe.

## Interface

Parameters:

- `CLK_DIV`, 50: clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz).
- `SAMPLE_PERIOD`, 10_000_000: clk cycles between read-transaction starts (10 Hz).
- `POWERUP_WAIT`, 600_000: clk cycles idle after reset before configuring (6 ms).
- `CS_GAP`, 2: minimum SCLK half-periods with `cs_n` high between transactions.

Ports:

- `clk` in, 1: 100 MHz system clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `miso` in, 1: SPI data from the accelerometer, asynchronous to `clk`.
- `sclk` out, 1: SPI clock, mode 0 (idles low).
- `mosi` out, 1: SPI data to the accelerometer.
- `cs_n` out, 1: SPI chip select, active low.
- `acl_data` out, 15: {X[7:3], Y[7:3], Z[7:3]}; each field is two's complement.
- `acl_valid` out, 1: one-cycle pulse when `acl_data` changes.

## Operation

- State machine sequence: WAIT_PWR → CFG → IDLE → READ → LATCH → IDLE…
- WAIT_PWR: counts `POWERUP_WAIT` cycles with `cs_n`=1, then moves to CFG.
- CFG: one 3-byte write transaction, bytes 0x0A (write cmd), 0x2D (POWER_CTL), 0x02 (measure mode). Then IDLE.
- Sample timer:
  - The first READ starts on the first IDLE cycle after CFG.
  - After that, READ starts `SAMPLE_PERIOD` cycles after the previous READ start.
  - If that point falls inside a transaction or its CS gap, READ starts on the first IDLE cycle after the gap. The missed tick is not queued twice.
- READ: one 5-byte burst. MOSI sends 0x0B (read cmd), 0x08 (XDATA), then 0x00 ×3. MISO bytes 3–5 are captured as X, Y, Z.
- LATCH: single cycle. `acl_data` ← {X[7:3], Y[7:3], Z[7:3]} and `acl_valid`=1. Then IDLE.
- SPI mode 0 framing:
  - `cs_n` falls one half-period before the first SCLK rise.
  - `cs_n` stays low across all bytes of a transaction.
  - `cs_n` rises one half-period after the last SCLK fall.
  - Between transactions `cs_n` is held high for ≥`CS_GAP` half-periods.
- Bit order is MSB first.
  - MOSI changes only while SCLK is low: at `cs_n` fall for bit 7, then at each SCLK fall.
  - MISO goes through a 2-flop synchroniser. The synchronised value is captured on the clk cycle SCLK is driven high.
- No back-pressure: the consumer samples `acl_data` whenever it likes. Intermediate byte values never appear on `acl_data`.

## Timing

- Reset values (applied asynchronously while `rst_n`=0): `cs_n`=1, `sclk`=0, `mosi`=0, `acl_data`=0, `acl_valid`=0, state WAIT_PWR, all counters 0.
- Reset takes effect mid-transaction:
  - `cs_n` goes high and `sclk` low immediately.
  - After release the block repeats WAIT_PWR and CFG before any READ.
- Byte duration is 16·`CLK_DIV` clk cycles.
- READ duration, `cs_n` fall to `cs_n` rise: 81·`CLK_DIV` cycles (80 half-periods for 5 bytes plus the lead-in half-period).
- Latency from the last SCLK rise (Z bit 0) to `acl_data` update is ≤ `CLK_DIV`+2 cycles. `acl_valid` is high in the same cycle as the update.
- Per-read arithmetic is bit selection only; fields are not sign-extended or saturated.
- `SAMPLE_PERIOD` smaller than the READ duration plus the gap gives back-to-back reads. This is legal.

## Structure

- Shared package `acl_pkg` holds:
  - the command constants (0x0A, 0x0B) and register addresses (0x2D, 0x08);
  - the POWER_CTL value 0x02;
  - the state enum.
- Sub-module `spi_byte_engine` handles one byte:
  - Inputs: `start`, `tx_byte`.
  - Outputs: `rx_byte`, `done`.
  - It owns `sclk`/`mosi` and the half-period divider.
- The parent sequences bytes and drives `cs_n`.

## Test plan

- Reset: hold `rst_n`=0 → `cs_n`=1, `sclk`=0, `acl_data`=0x0000, `acl_valid`=0. No SCLK edge before `POWERUP_WAIT` cycles after release.
- Configuration: SPI monitor captures exactly 3 MOSI bytes, 0x0A, 0x2D, 0x02, under one low `cs_n`, with SCLK period 100 clk.
- Read: slave model returns X=0xF8, Y=0x10, Z=0x40 → MOSI is 0x0B, 0x08, 0x00, 0x00, 0x00. `acl_data`=0x7C48 with a single `acl_valid` pulse.
- Rate: 3 consecutive reads with `SAMPLE_PERIOD`=10_000 → READ starts exactly 10_000 cycles apart. `acl_data` is stable between pulses.
- Boundary: MISO tied high → `acl_data`=0x7FFF. MISO tied low → `acl_data`=0x0000, `acl_valid` still pulses.
- Mid-read reset: assert `rst_n` during byte 4 → `cs_n` high within the same cycle and `acl_data`=0. After release, a full CFG transaction occurs before the next READ.
